// File: rtl/ni_packet_injector.sv
// Network-interface transmitter: turns one packet command plus a payload stream into
// header/body/tail flits with even parity, paced by the router's RTS/CTS flow control.
//
// Handshakes: cmd is taken on the edge where cmd_valid && cmd_ready; a payload word is
// taken on the edge where pl_valid && pl_ready; a flit launches at edge k only when
// DCTS==1 at edge k, and RTS is high for exactly the one cycle after that edge.
module ni_packet_injector #(
  parameter int         DATA_WIDTH = 32,
  parameter logic [3:0] SRC_ADDR   = 4'b0000,
  parameter int         PID_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [3:0]            cmd_dst,
  input  logic [11:0]           cmd_len,
  input  logic                  pl_valid,
  output logic                  pl_ready,
  input  logic [27:0]           pl_data,
  output logic [DATA_WIDTH-1:0] TX,
  output logic                  RTS,
  input  logic                  DCTS,
  output logic                  busy,
  output logic                  pkt_sent,
  output logic [1:0]            dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    PAY  = 2'd2
  } state_t;

  state_t                 r_state;
  state_t                 w_next;
  logic                   r_cmd_ready;
  logic [3:0]             r_dst;
  logic [11:0]            r_len;
  logic [11:0]            r_rem;
  logic [PID_WIDTH-1:0]   r_pid;
  logic [DATA_WIDTH-1:0]  r_tx;
  logic                   r_rts;
  logic                   r_pkt_sent;

  logic                   w_accept;
  logic                   w_pl_fire;
  logic                   w_is_tail;
  logic [11:0]            w_eff_len;
  logic [30:0]            w_hdr_bits;
  logic [30:0]            w_pay_bits;

  assign w_eff_len  = (cmd_len < 12'd2) ? 12'd2 : cmd_len;
  assign w_accept   = (r_state == IDLE) && cmd_valid && r_cmd_ready;
  assign pl_ready   = (r_state == PAY) && DCTS && (r_rem != 12'd0);
  assign w_pl_fire  = pl_valid && pl_ready;
  assign w_is_tail  = (r_rem == 12'd1);
  assign w_hdr_bits = {3'b001, r_len, r_dst, SRC_ADDR, r_pid};
  assign w_pay_bits = {(w_is_tail ? 3'b100 : 3'b010), pl_data};

  assign cmd_ready = r_cmd_ready;
  assign busy      = (r_state != IDLE);
  assign TX        = r_tx;
  assign RTS       = r_rts;
  assign pkt_sent  = r_pkt_sent;
  assign dbg_state = r_state;

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next = HDR;
      HDR:     if (DCTS) w_next = PAY;
      PAY:     if (w_pl_fire && w_is_tail) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_cmd_ready <= 1'b0;
      r_dst       <= '0;
      r_len       <= '0;
      r_rem       <= '0;
      r_pid       <= '0;
      r_tx        <= '0;
      r_rts       <= 1'b0;
      r_pkt_sent  <= 1'b0;
    end else begin
      r_state     <= w_next;
      // cmd_ready rises one cycle after reset release and tracks IDLE thereafter.
      r_cmd_ready <= (w_next == IDLE);
      r_rts       <= 1'b0;
      r_pkt_sent  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_dst <= cmd_dst;
            r_len <= w_eff_len;
            r_rem <= w_eff_len - 12'd1;
          end
        end
        HDR: begin
          if (DCTS) begin
            r_tx  <= {w_hdr_bits, ^w_hdr_bits};
            r_rts <= 1'b1;
          end
        end
        PAY: begin
          if (w_pl_fire) begin
            r_tx  <= {w_pay_bits, ^w_pay_bits};
            r_rts <= 1'b1;
            r_rem <= r_rem - 12'd1;
            if (w_is_tail) begin
              r_pkt_sent <= 1'b1;
              r_pid      <= r_pid + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ni_packet_injector.sv
// Bench for ni_packet_injector: directed and random packets checked against a flit-list
// model built straight from the packet format rules.
module tb_ni_packet_injector;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  cmd_dst;
  logic [11:0] cmd_len;
  logic        pl_valid;
  logic        pl_ready;
  logic [27:0] pl_data;
  logic [31:0] TX;
  logic        RTS;
  logic        DCTS;
  logic        busy;
  logic        pkt_sent;
  logic [1:0]  dbg_state;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];
  logic [7:0]  pid_m = 8'd0;
  logic        dcts_at_edge = 1'b1;
  int          run = 0;
  int          max_run = 0;

  ni_packet_injector dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_dst(cmd_dst), .cmd_len(cmd_len), .pl_valid(pl_valid), .pl_ready(pl_ready),
    .pl_data(pl_data), .TX(TX), .RTS(RTS), .DCTS(DCTS), .busy(busy),
    .pkt_sent(pkt_sent), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk_flit(input logic [2:0] t, input logic [27:0] body);
    logic [31:0] f;
    f    = {t, body, 1'b0};
    f[0] = ^f[31:1];
    return f;
  endfunction

  // Valid/ready semantics: a transfer happens on the rising edge where both are high.
  always @(posedge clk) dcts_at_edge <= DCTS;

  always @(negedge clk) begin
    logic [31:0] e;
    if (rst) begin
      chk("rdy_vs_busy", 32'(cmd_ready && busy), 32'd0);
      if (!DCTS) chk("pl_ready_stall", 32'(pl_ready), 32'd0);
      if (RTS) begin
        run++;
        if (run > max_run) max_run = run;
        chk("rts_needs_dcts", 32'(dcts_at_edge), 32'd1);
        chk("parity", 32'(^TX), 32'd0);
        chk("pkt_sent_tail", 32'(pkt_sent), 32'(TX[31]));
        if (exp_q.size() == 0) chk("extra_flit", 32'(exp_q.size()), 32'd1);
        else begin
          e = exp_q.pop_front();
          chk("flit", TX, e);
        end
      end else begin
        run = 0;
        chk("pkt_sent_idle", 32'(pkt_sent), 32'd0);
      end
    end
  end

  // Builds the expected flits for one command and returns the payload words to feed.
  task automatic model_pkt(input int len, input int dst, output logic [27:0] pl[$]);
    int          eff;
    logic [11:0] l12;
    logic [3:0]  d4;
    logic [31:0] r32;
    eff = (len < 2) ? 2 : len;
    l12 = 12'(eff);
    d4  = 4'(dst);
    pl.delete();
    exp_q.push_back(mk_flit(3'b001, {l12, d4, 4'b0000, pid_m}));
    for (int i = 0; i < eff - 1; i++) begin
      r32 = $urandom();
      pl.push_back(r32[27:0]);
      exp_q.push_back(mk_flit((i == eff - 2) ? 3'b100 : 3'b010, r32[27:0]));
    end
    pid_m = pid_m + 8'd1;
  endtask

  task automatic issue_cmd(input int len, input int dst);
    int k;
    cmd_valid = 1'b1;
    cmd_len   = 12'(len);
    cmd_dst   = 4'(dst);
    for (k = 0; k < 50; k++) begin
      @(negedge clk);
      if (cmd_ready) break;
    end
    chk("cmd_accept", 32'(cmd_ready), 32'd1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic run_pkt(input int len, input int dst, input bit gap, input bit stall, input bit rnd);
    logic [27:0] pl[$];
    int idx;
    int c;
    bit hs;
    max_run = 0;
    model_pkt(len, dst, pl);
    issue_cmd(len, dst);
    idx = 0;
    c   = 0;
    while (idx < pl.size() && c < 200) begin
      if (rnd) DCTS = ($urandom_range(0, 3) != 0);
      else     DCTS = !(stall && c >= 1 && c <= 3);
      if (rnd)      pl_valid = ($urandom_range(0, 2) != 0);
      else if (gap) pl_valid = (c % 2 == 1);
      else          pl_valid = 1'b1;
      pl_data = pl[idx];
      @(negedge clk);
      hs = pl_valid && pl_ready;
      @(posedge clk);
      #1;
      if (hs) idx++;
      c++;
    end
    pl_valid = 1'b0;
    DCTS     = 1'b1;
    chk("payload_done", 32'(idx), 32'(pl.size()));
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (!busy) break;
    end
    chk("pkt_end_busy", 32'(busy), 32'd0);
    @(negedge clk);
    chk("exp_empty", 32'(exp_q.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [27:0] pl[$];
    bit hs;
    int i;
    rst = 1'b0; cmd_valid = 1'b0; cmd_dst = '0; cmd_len = '0;
    pl_valid = 1'b0; pl_data = '0; DCTS = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_tx", TX, 32'd0);
    chk("rst_rts", 32'(RTS), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("rst_pl_ready", 32'(pl_ready), 32'd0);
    chk("rst_pkt_sent", 32'(pkt_sent), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;

    run_pkt(4, 3, 1'b0, 1'b0, 1'b0);
    chk("t1_rts_run", 32'(max_run), 32'd4);
    run_pkt(0, 5, 1'b0, 1'b0, 1'b0);
    chk("t2_rts_run", 32'(max_run), 32'd2);
    run_pkt(4, 3, 1'b0, 1'b1, 1'b0);
    run_pkt(4, 3, 1'b1, 1'b0, 1'b0);
    chk("t4_no_burst", 32'(max_run <= 2), 32'd1);
    run_pkt(1, 9, 1'b0, 1'b0, 1'b1);

    for (int p = 0; p < 257; p++)
      run_pkt($urandom_range(0, 7), $urandom_range(0, 15), 1'b0, 1'b0, 1'b1);

    model_pkt(8, 6, pl);
    issue_cmd(8, 6);
    i = 0;
    for (int c = 0; c < 3; c++) begin
      DCTS = 1'b1; pl_valid = 1'b1; pl_data = pl[i];
      @(negedge clk);
      hs = pl_valid && pl_ready;
      @(posedge clk); #1;
      if (hs) i++;
    end
    chk("abort_bodies_taken", 32'(i), 32'd2);
    #2;
    rst = 1'b0;
    #1;
    chk("abort_tx", TX, 32'd0);
    chk("abort_rts", 32'(RTS), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_pl_ready", 32'(pl_ready), 32'd0);
    pl_valid = 1'b0;
    exp_q.delete();
    pid_m = 8'd0;
    repeat (2) @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    run_pkt(3, 2, 1'b0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
